// File: rtl/sprite_motion_ctrl.sv
// Per-frame position/velocity engine for one square sprite: keyboard steering,
// speed levels, pause toggle and wall bounce with a one-frame Bounce strobe.
module sprite_motion_ctrl #(
  parameter int X_MIN     = 0,
  parameter int X_MAX     = 639,
  parameter int Y_MIN     = 0,
  parameter int Y_MAX     = 479,
  parameter int X_CENTER  = 320,
  parameter int Y_CENTER  = 240,
  parameter int SIZE      = 4,
  parameter int STEP      = 1,
  parameter int MAX_SPEED = 4,
  parameter int KEY_UP    = 26,
  parameter int KEY_DOWN  = 22,
  parameter int KEY_RIGHT = 7,
  parameter int KEY_LEFT  = 4,
  parameter int KEY_FAST  = 46,
  parameter int KEY_SLOW  = 45,
  parameter int KEY_PAUSE = 19
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic [15:0] keycode,
  output logic [9:0]  BallX,
  output logic [9:0]  BallY,
  output logic [9:0]  BallS,
  output logic        Bounce,
  output logic        Paused,
  output logic [2:0]  Speed
);

  typedef enum logic {RUN = 1'b0, PAUSED = 1'b1} state_t;

  localparam logic signed [10:0] X_LO   = 11'(X_MIN + SIZE);
  localparam logic signed [10:0] X_HI   = 11'(X_MAX - SIZE);
  localparam logic signed [10:0] Y_LO   = 11'(Y_MIN + SIZE);
  localparam logic signed [10:0] Y_HI   = 11'(Y_MAX - SIZE);
  localparam logic signed [10:0] STEP_S = 11'(STEP);
  localparam logic [2:0]         SPD_MAX = 3'(MAX_SPEED);

  state_t             state, state_next;
  logic [15:0]        prev_key;
  logic [9:0]         pos_x, pos_y, pos_x_next, pos_y_next;
  logic signed [10:0] vel_x, vel_y, vel_x_next, vel_y_next;
  logic signed [10:0] vx_dir, vy_dir, cand_x, cand_y, mag;
  logic [2:0]         speed, speed_next;
  logic               bounce, bounce_next;
  logic               new_key, fast_edge, slow_edge, pause_edge;

  function automatic logic signed [10:0] rescale(input logic signed [10:0] v,
                                                 input logic signed [10:0] m);
    if (v > 11'sd0)      rescale = m;
    else if (v < 11'sd0) rescale = -m;
    else                 rescale = 11'sd0;
  endfunction

  function automatic logic signed [10:0] wall_vel(input logic signed [10:0] cand,
                                                  input logic signed [10:0] v,
                                                  input logic signed [10:0] m,
                                                  input logic signed [10:0] lo,
                                                  input logic signed [10:0] hi);
    if (cand > hi)      wall_vel = -m;
    else if (cand < lo) wall_vel = m;
    else                wall_vel = v;
  endfunction

  function automatic logic [9:0] clamp_pos(input logic signed [10:0] cand,
                                           input logic signed [10:0] lo,
                                           input logic signed [10:0] hi);
    logic signed [10:0] r;
    if (cand > hi)      r = hi;
    else if (cand < lo) r = lo;
    else                r = cand;
    clamp_pos = 10'(r);
  endfunction

  assign new_key    = (keycode != prev_key);
  assign fast_edge  = new_key && (keycode == 16'(KEY_FAST));
  assign slow_edge  = new_key && (keycode == 16'(KEY_SLOW));
  assign pause_edge = new_key && (keycode == 16'(KEY_PAUSE));

  // The step lands on the un-reversed candidate (clamped into the field); the
  // reversed velocity takes effect from the following frame.
  always_comb begin
    state_next  = state;
    speed_next  = speed;
    mag         = 11'sd0;
    vx_dir      = vel_x;
    vy_dir      = vel_y;
    cand_x      = $signed({1'b0, pos_x});
    cand_y      = $signed({1'b0, pos_y});
    vel_x_next  = vel_x;
    vel_y_next  = vel_y;
    pos_x_next  = pos_x;
    pos_y_next  = pos_y;
    bounce_next = 1'b0;
    case (state)
      RUN: begin
        if (pause_edge) begin
          state_next = PAUSED;
        end else begin
          if (fast_edge && (speed < SPD_MAX))   speed_next = speed + 3'd1;
          else if (slow_edge && (speed > 3'd1)) speed_next = speed - 3'd1;
          else                                  speed_next = speed;
          mag = $signed({8'd0, speed_next}) * STEP_S;
          if (keycode == 16'(KEY_UP)) begin
            vx_dir = 11'sd0;  vy_dir = -mag;
          end else if (keycode == 16'(KEY_DOWN)) begin
            vx_dir = 11'sd0;  vy_dir = mag;
          end else if (keycode == 16'(KEY_RIGHT)) begin
            vx_dir = mag;     vy_dir = 11'sd0;
          end else if (keycode == 16'(KEY_LEFT)) begin
            vx_dir = -mag;    vy_dir = 11'sd0;
          end else begin
            vx_dir = rescale(vel_x, mag);
            vy_dir = rescale(vel_y, mag);
          end
          cand_x      = $signed({1'b0, pos_x}) + vx_dir;
          cand_y      = $signed({1'b0, pos_y}) + vy_dir;
          vel_x_next  = wall_vel(cand_x, vx_dir, mag, X_LO, X_HI);
          vel_y_next  = wall_vel(cand_y, vy_dir, mag, Y_LO, Y_HI);
          pos_x_next  = clamp_pos(cand_x, X_LO, X_HI);
          pos_y_next  = clamp_pos(cand_y, Y_LO, Y_HI);
          bounce_next = (vel_x_next != vx_dir) || (vel_y_next != vy_dir);
        end
      end
      PAUSED: begin
        if (pause_edge) state_next = RUN;
        else            state_next = PAUSED;
      end
      default: state_next = RUN;
    endcase
  end

  // Frame state register
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state    <= RUN;
      prev_key <= 16'd0;
      pos_x    <= 10'(X_CENTER);
      pos_y    <= 10'(Y_CENTER);
      vel_x    <= 11'sd0;
      vel_y    <= 11'sd0;
      speed    <= 3'd1;
      bounce   <= 1'b0;
    end else begin
      state    <= state_next;
      prev_key <= keycode;
      pos_x    <= pos_x_next;
      pos_y    <= pos_y_next;
      vel_x    <= vel_x_next;
      vel_y    <= vel_y_next;
      speed    <= speed_next;
      bounce   <= bounce_next;
    end
  end

  assign BallX  = pos_x;
  assign BallY  = pos_y;
  assign BallS  = 10'(SIZE);
  assign Bounce = bounce;
  assign Paused = (state == PAUSED);
  assign Speed  = speed;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Directed bench for sprite_motion_ctrl: reset, steering, speed levels,
// wall bounce, pause and asynchronous reset, with hand-computed expectations.
module tb_sprite_motion_ctrl;

  logic        frame_clk;
  logic        Reset;
  logic [15:0] keycode;
  logic [9:0]  BallX, BallY, BallS;
  logic        Bounce, Paused;
  logic [2:0]  Speed;

  int checks = 0;
  int errors = 0;

  sprite_motion_ctrl dut (
    .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode),
    .BallX(BallX), .BallY(BallY), .BallS(BallS),
    .Bounce(Bounce), .Paused(Paused), .Speed(Speed)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1; keycode = 16'd0;
    #12 Reset = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    checks++; if (BallX !== 10'd320) begin errors++; $display("FAIL reset_x got %0d want 320", BallX); end
    checks++; if (BallY !== 10'd240) begin errors++; $display("FAIL reset_y got %0d want 240", BallY); end
    checks++; if (Bounce !== 1'b0) begin errors++; $display("FAIL reset_bounce got %0b want 0", Bounce); end
    checks++; if (Speed !== 3'd1) begin errors++; $display("FAIL reset_speed got %0d want 1", Speed); end
    checks++; if (Paused !== 1'b0) begin errors++; $display("FAIL reset_paused got %0b want 0", Paused); end
    checks++; if (BallS !== 10'd4) begin errors++; $display("FAIL ball_size got %0d want 4", BallS); end
  endtask

  task automatic test_move_right();
    keycode = 16'd7;
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++; if (BallX !== 10'(320 + i)) begin errors++; $display("FAIL right_x[%0d] got %0d want %0d", i, BallX, 320 + i); end
      checks++; if (BallY !== 10'd240) begin errors++; $display("FAIL right_y[%0d] got %0d want 240", i, BallY); end
    end
  endtask

  task automatic test_speed();
    int exp_x[10];
    int exp_s[10];
    exp_x = '{327, 329, 332, 335, 339, 343, 347, 351, 355, 359};
    exp_s = '{2, 2, 3, 3, 4, 4, 4, 4, 4, 4};
    for (int i = 0; i < 10; i++) begin
      keycode = (i % 2 == 0) ? 16'd46 : 16'd0;
      tick();
      checks++; if (BallX !== 10'(exp_x[i])) begin errors++; $display("FAIL fast_x[%0d] got %0d want %0d", i, BallX, exp_x[i]); end
      checks++; if (Speed !== 3'(exp_s[i])) begin errors++; $display("FAIL fast_speed[%0d] got %0d want %0d", i, Speed, exp_s[i]); end
    end
    keycode = 16'd4;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++; if (BallX !== 10'(359 - 4 * i)) begin errors++; $display("FAIL left_x[%0d] got %0d want %0d", i, BallX, 359 - 4 * i); end
    end
  endtask

  task automatic test_bounce();
    int keys[8];
    keys = '{7, 0, 0, 46, 0, 46, 0, 46};
    // mid-frame reset pulse, then walk to X=633 at speed 4
    Reset = 1'b1; #2 Reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      keycode = 16'(keys[i]);
      tick();
    end
    checks++; if (BallX !== 10'd337) begin errors++; $display("FAIL setup_x got %0d want 337", BallX); end
    keycode = 16'd0;
    for (int i = 0; i < 74; i++) tick();
    checks++; if (BallX !== 10'd633) begin errors++; $display("FAIL pre_wall_x got %0d want 633", BallX); end
    checks++; if (Speed !== 3'd4) begin errors++; $display("FAIL pre_wall_speed got %0d want 4", Speed); end
    tick();
    checks++; if (BallX !== 10'd635) begin errors++; $display("FAIL wall_x got %0d want 635", BallX); end
    checks++; if (Bounce !== 1'b1) begin errors++; $display("FAIL wall_bounce got %0b want 1", Bounce); end
    tick();
    checks++; if (BallX !== 10'd631) begin errors++; $display("FAIL after_wall_x got %0d want 631", BallX); end
    checks++; if (Bounce !== 1'b0) begin errors++; $display("FAIL after_wall_bounce got %0b want 0", Bounce); end
  endtask

  task automatic test_pause();
    int keys[6];
    keys = '{19, 0, 45, 26, 26, 26};
    for (int i = 0; i < 6; i++) begin
      keycode = 16'(keys[i]);
      tick();
      checks++; if (Paused !== 1'b1) begin errors++; $display("FAIL paused[%0d] got %0b want 1", i, Paused); end
      checks++; if (BallX !== 10'd631 || BallY !== 10'd240) begin errors++; $display("FAIL pause_hold[%0d] got %0d,%0d want 631,240", i, BallX, BallY); end
      checks++; if (Speed !== 3'd4) begin errors++; $display("FAIL pause_speed[%0d] got %0d want 4", i, Speed); end
    end
    keycode = 16'd19;
    tick();
    checks++; if (Paused !== 1'b0) begin errors++; $display("FAIL unpause got %0b want 0", Paused); end
    checks++; if (BallY !== 10'd240) begin errors++; $display("FAIL unpause_y got %0d want 240", BallY); end
    keycode = 16'd26;
    tick();
    checks++; if (BallY !== 10'd236 || BallX !== 10'd631) begin errors++; $display("FAIL up1 got %0d,%0d want 631,236", BallX, BallY); end
    tick();
    checks++; if (BallY !== 10'd232) begin errors++; $display("FAIL up2 got %0d want 232", BallY); end
    keycode = 16'd45;
    tick();
    checks++; if (Speed !== 3'd3) begin errors++; $display("FAIL slow_speed got %0d want 3", Speed); end
    checks++; if (BallY !== 10'd229) begin errors++; $display("FAIL slow_y got %0d want 229", BallY); end
    checks++; if (Bounce !== 1'b0) begin errors++; $display("FAIL slow_bounce got %0b want 0", Bounce); end
  endtask

  task automatic test_async_reset();
    #2 Reset = 1'b1;
    #1;
    checks++; if (BallX !== 10'd320 || BallY !== 10'd240) begin errors++; $display("FAIL async_pos got %0d,%0d want 320,240", BallX, BallY); end
    checks++; if (Speed !== 3'd1) begin errors++; $display("FAIL async_speed got %0d want 1", Speed); end
    checks++; if (Paused !== 1'b0 || Bounce !== 1'b0) begin errors++; $display("FAIL async_flags got %0b%0b want 00", Paused, Bounce); end
    Reset = 1'b0; keycode = 16'd0;
    tick();
    checks++; if (BallX !== 10'd320 || BallY !== 10'd240) begin errors++; $display("FAIL post_reset_pos got %0d,%0d want 320,240", BallX, BallY); end
  endtask

  initial begin
    test_reset();
    test_move_right();
    test_speed();
    test_bounce();
    test_pause();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
